sha2_compress_core: RTL and testbench

Parametrised SHA-256/SHA-224 compression engine: accepts one 512-bit message block plus a chaining value or standard IV over a valid/ready handshake, expands the message schedule internally, performs 64 rounds at ROUNDS_PER_CYCLE rounds per clock, and returns the feed-forward digest over a valid/ready output. It sits between the block padder/scheduler and the digest sink, and supersedes the fixed 1-round, externally scheduled pipe.

---
 rtl/sha2_pkg.sv | 77 +++++++
 rtl/sha2_round.sv | 27 ++
 rtl/sha2_compress_core.sv | 128 ++++++++++++
 tb/tb_sha2_compress_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha2_pkg
// Purpose  : Shared SHA-256/SHA-224 constants, FSM encoding and round helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sha2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] IV_SEL_H      = 2'd0;
   localparam logic [1:0] IV_SEL_SHA256 = 2'd1;
   localparam logic [1:0] IV_SEL_SHA224 = 2'd2;

   localparam logic [255:0] IV_SHA256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [255:0] IV_SHA224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] S0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] S1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sha2_round.sv
`default_nettype none
// ============================================================================
// Module   : sha2_round
// Purpose  : One combinational SHA-2 round; state packed a..h with a at 255:224.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_round
   import sha2_pkg::*;
(
   input  logic [255:0] st_in,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] st_out
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   always_comb begin
      {a, b, c, d, e, f, g, h} = st_in;
      t1     = h + S1(e) + ch(e, f, g) + k + w;
      t2     = S0(a) + maj(a, b, c);
      st_out = {t1 + t2, a, b, c, d + t1, e, f, g};
   end

endmodule
`default_nettype wire

// File: rtl/sha2_compress_core.sv
`default_nettype none
// ============================================================================
// Module   : sha2_compress_core
// Purpose  : SHA-256/224 compression, internal schedule, R rounds per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_compress_core
   import sha2_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic [255:0] in_h,
   input  logic [1:0]   in_iv_sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   localparam int         R      = ROUNDS_PER_CYCLE;
   localparam logic [6:0] R_STEP = 7'(R);

   state_t state, state_next;

   logic [6:0]   cnt;
   logic [6:0]   cnt_next;
   logic [255:0] base_h;
   logic [255:0] work;
   logic [255:0] digest_q;
   logic [255:0] sel_h;
   logic [255:0] fin_sum;
   logic [31:0]  win [0:15];
   logic [31:0]  ext [0:15+R];
   logic [R-1:0][31:0] k_vec;
   logic [R:0][255:0]  chain;
   logic         accept;

   // in_ready follows out_ready in HOLD so a new block can overlap the drain.
   assign in_ready   = reset & ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
   assign accept     = in_valid & in_ready;
   assign out_valid  = (state == ST_HOLD);
   assign busy       = (state == ST_ROUND) | (state == ST_FINAL);
   assign out_digest = digest_q;
   assign cnt_next   = cnt + R_STEP;

   always_comb begin
      case (in_iv_sel)
         IV_SEL_SHA256: sel_h = IV_SHA256;
         IV_SEL_SHA224: sel_h = IV_SHA224;
         default:       sel_h = in_h;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (accept) state_next = ST_ROUND;
         ST_ROUND: if (cnt_next == 7'd64) state_next = ST_FINAL;
         ST_FINAL: state_next = ST_HOLD;
         ST_HOLD:  if (out_ready) state_next = accept ? ST_ROUND : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Extended window: the 16 live words plus R freshly scheduled ones, so
   // later new words can depend on earlier new words within the same clock.
   always_comb begin
      for (int i = 0; i < 16 + R; i++) ext[i] = '0;
      for (int i = 0; i < 16; i++) ext[i] = win[i];
      for (int j = 0; j < R; j++)
         ext[16+j] = s1(ext[14+j]) + ext[9+j] + s0(ext[1+j]) + ext[j];
   end

   always_comb begin
      k_vec = '0;
      for (int j = 0; j < R; j++) k_vec[j] = K[cnt[5:0] + 6'(j)];
   end

   assign chain[0] = work;

   for (genvar gi = 0; gi < R; gi++) begin : g_round
      sha2_round u_round (
         .st_in  (chain[gi]),
         .k      (k_vec[gi]),
         .w      (win[gi]),
         .st_out (chain[gi+1])
      );
   end

   always_comb begin
      fin_sum = '0;
      for (int i = 0; i < 8; i++)
         fin_sum[i*32 +: 32] = base_h[i*32 +: 32] + work[i*32 +: 32];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         base_h   <= '0;
         work     <= '0;
         digest_q <= '0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else if (accept) begin
         cnt    <= '0;
         base_h <= sel_h;
         work   <= sel_h;
         for (int i = 0; i < 16; i++) win[i] <= in_block[511 - 32*i -: 32];
      end else if (state == ST_ROUND) begin
         cnt  <= cnt_next;
         work <= chain[R];
         for (int i = 0; i < 16; i++) win[i] <= ext[i+R];
      end else if (state == ST_FINAL) begin
         digest_q <= fin_sum;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sha2_compress_core.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for sha2_compress_core: directed SHA-256/224 vectors,
// chaining, backpressure, mid-round reset, and an R=2/4/8 latency sweep.
module tb_sha2_compress_core;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_block;
   logic [255:0] in_h;
   logic [1:0]   in_iv_sel;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_digest;
   logic         busy;
   logic         sw_go;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK2 = {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] D256_ABC = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [255:0] D224_ABC = {
      32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
      32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
   localparam logic [255:0] H1 = {
      32'h85e655d6, 32'h417a1795, 32'h3363376a, 32'h624cde5c,
      32'h76e09589, 32'hcac5f811, 32'hcc4b32c1, 32'hf20e533a};
   localparam logic [255:0] D_TWO = {
      32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
   localparam logic [255:0] MASK_ALL = {256{1'b1}};
   localparam logic [255:0] MASK_224 = {{224{1'b1}}, 32'h0};

   typedef struct {
      logic [255:0] dig;
      logic [255:0] mask;
      int           lat;
      string        name;
   } exp_t;

   exp_t         exp_q[$];
   int           acc_q[$];
   bit           cur_active = 1'b0;
   logic [255:0] held;
   exp_t         mon_e;
   int           mon_a;

   sha2_compress_core #(.ROUNDS_PER_CYCLE(1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .in_h       (in_h),
      .in_iv_sel  (in_iv_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_digest (out_digest),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [255:0] d, input logic [255:0] m,
                               input int lat, input string name);
      exp_t e;
      e.dig = d; e.mask = m; e.lat = lat; e.name = name;
      return e;
   endfunction

   // Monitor: pops one expectation each time a new digest is presented.
   always @(negedge clk) begin
      if (!reset) begin
         cur_active = 1'b0;
         acc_q.delete();
      end else begin
         if (out_valid) begin
            if (!cur_active) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_out_valid actual=%h required=no_output", out_digest);
               end else begin
                  mon_e = exp_q.pop_front();
                  check(mon_e.name, out_digest & mon_e.mask, mon_e.dig & mon_e.mask);
                  if (acc_q.size() > 0) begin
                     mon_a = acc_q.pop_front();
                     check({mon_e.name, "_latency"}, 256'(cyc - mon_a - 1), 256'(mon_e.lat));
                  end else begin
                     total++; bad++;
                     $display("FAIL %s_accept actual=none required=recorded_accept", mon_e.name);
                  end
               end
               cur_active = 1'b1;
               held       = out_digest;
            end else begin
               check("hold_stable", out_digest, held);
            end
            if (out_ready) cur_active = 1'b0;
         end
         if (in_valid && in_ready) acc_q.push_back(cyc);
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int RV = 2 << gi;
      logic         rdy;
      logic         vld;
      logic         bsy;
      logic [255:0] dig;
      int           acc  = 0;
      int           seen = 0;

      sha2_compress_core #(.ROUNDS_PER_CYCLE(RV)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .in_valid   (sw_go),
         .in_ready   (rdy),
         .in_block   (in_block),
         .in_h       (in_h),
         .in_iv_sel  (in_iv_sel),
         .out_valid  (vld),
         .out_ready  (1'b1),
         .out_digest (dig),
         .busy       (bsy)
      );

      always @(negedge clk) begin
         if (reset && sw_go && rdy) acc = cyc;
         if (reset && vld) begin
            seen++;
            check($sformatf("sweep_r%0d_digest", RV), dig, D256_ABC);
            check($sformatf("sweep_r%0d_latency", RV), 256'(cyc - acc - 1), 256'(64 / RV + 1));
         end
      end
   end

   task automatic send(input logic [511:0] blk, input logic [255:0] h, input logic [1:0] sel,
                       input exp_t e, input bit expect_out);
      int n;
      in_block  = blk;
      in_h      = h;
      in_iv_sel = sel;
      in_valid  = 1'b1;
      if (expect_out) exp_q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL %s_accept_timeout actual=in_ready_low required=accept", e.name);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_block  = ~blk;
      in_h      = ~h;
      in_iv_sel = 2'd1 - sel;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && !out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sw_go     = 1'b0;
      in_block  = '0;
      in_h      = '0;
      in_iv_sel = 2'd0;

      @(negedge clk);
      check("reset_out_valid", 256'(out_valid), 256'(0));
      check("reset_in_ready", 256'(in_ready), 256'(0));
      check("reset_busy", 256'(busy), 256'(0));
      check("reset_digest", out_digest, 256'(0));
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // SHA-256 "abc", with the R sweep accepting the same block together
      sw_go = 1'b1;
      send(ABC_BLK, '0, 2'd1, mk(D256_ABC, MASK_ALL, 65, "sha256_abc"), 1'b1);
      sw_go = 1'b0;
      drain();

      send(ABC_BLK, '0, 2'd2, mk(D224_ABC, MASK_224, 65, "sha224_abc"), 1'b1);
      drain();

      send(BLK1, '0, 2'd1, mk(H1, MASK_ALL, 65, "two_block_1"), 1'b1);
      send(BLK2, H1, 2'd0, mk(D_TWO, MASK_ALL, 65, "two_block_2"), 1'b1);
      send(BLK2, H1, 2'd3, mk(D_TWO, MASK_ALL, 65, "two_block_sel3"), 1'b1);
      drain();

      // Backpressure, then an accept overlapping the drain handshake
      out_ready = 1'b0;
      send(ABC_BLK, '0, 2'd1, mk(D256_ABC, MASK_ALL, 65, "bp_first"), 1'b1);
      for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_in_ready", 256'(in_ready), 256'(0));
         check("bp_out_valid", 256'(out_valid), 256'(1));
      end
      @(posedge clk); #1;
      in_block  = ABC_BLK;
      in_iv_sel = 2'd2;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(mk(D224_ABC, MASK_224, 65, "bp_second"));
      @(negedge clk);
      check("bp_accept_ready", 256'(in_ready), 256'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_valid_drop", 256'(out_valid), 256'(0));
      check("bp_busy", 256'(busy), 256'(1));
      drain();

      // Reset 30 clocks into ROUND aborts the block
      send(ABC_BLK, '0, 2'd1, mk('0, MASK_ALL, 0, "aborted"), 1'b0);
      repeat (30) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midreset_out_valid", 256'(out_valid), 256'(0));
      check("midreset_busy", 256'(busy), 256'(0));
      check("midreset_in_ready", 256'(in_ready), 256'(0));
      check("midreset_digest", out_digest, 256'(0));
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("postreset_out_valid", 256'(out_valid), 256'(0));
      @(posedge clk); #1;
      send(ABC_BLK, '0, 2'd1, mk(D256_ABC, MASK_ALL, 65, "after_reset_abc"), 1'b1);
      drain();
      repeat (5) @(negedge clk);

      check("sweep_r2_count", 256'(g_sweep[0].seen), 256'(1));
      check("sweep_r4_count", 256'(g_sweep[1].seen), 256'(1));
      check("sweep_r8_count", 256'(g_sweep[2].seen), 256'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
